// File: rtl/iq_pu_arbiter_if.sv
// Bundles the FIFO, processing-unit and status signals of the I/Q PU arbiter.
// Latency: none, wires only.
// Backpressure: carries the empty/full and ready signals that stall the arbiter.
interface iq_pu_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  // input FIFOs (first-word-fall-through)
  logic                  i_rd_en;
  logic                  i_empty;
  logic [DATA_WIDTH-1:0] i_dout;
  logic                  q_rd_en;
  logic                  q_empty;
  logic [DATA_WIDTH-1:0] q_dout;
  // processing unit
  logic                  pu_valid;
  logic                  pu_ready;
  logic [DATA_WIDTH-1:0] pu_din;
  logic                  pu_out_valid;
  logic [DATA_WIDTH-1:0] pu_out;
  // output FIFOs
  logic                  i_out_wr_en;
  logic                  i_out_full;
  logic [DATA_WIDTH-1:0] i_out_din;
  logic                  q_out_wr_en;
  logic                  q_out_full;
  logic [DATA_WIDTH-1:0] q_out_din;
  // status
  logic                  active_ch;
  logic                  err_timeout;
  logic                  err_spurious;
  logic [CNT_WIDTH-1:0]  i_count;
  logic [CNT_WIDTH-1:0]  q_count;

  // arbiter side
  modport master (
    output i_rd_en, q_rd_en, pu_valid, pu_din, i_out_wr_en, i_out_din,
           q_out_wr_en, q_out_din, active_ch, err_timeout, err_spurious,
           i_count, q_count,
    input  i_empty, i_dout, q_empty, q_dout, pu_ready, pu_out_valid, pu_out,
           i_out_full, q_out_full
  );

  // FIFO / PU side
  modport slave (
    input  i_rd_en, q_rd_en, pu_valid, pu_din, i_out_wr_en, i_out_din,
           q_out_wr_en, q_out_din, active_ch, err_timeout, err_spurious,
           i_count, q_count,
    output i_empty, i_dout, q_empty, q_dout, pu_ready, pu_out_valid, pu_out,
           i_out_full, q_out_full
  );
endinterface

// File: rtl/iq_pu_arbiter.sv
// Round-robin shares one single-transaction PU between the I and Q sample streams.
// Latency: 4 cycles per sample (select, issue, wait >=1, write) with a 1-cycle PU.
// Backpressure: a channel is only picked when its input has data and its output has room; a full output holds the result.
module iq_pu_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic            clock,
  input  logic            reset,
  iq_pu_arbiter_if.master bus
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t                state, state_nxt;
  logic                  last_ch, last_ch_nxt;
  logic                  tag, tag_nxt;
  logic [DATA_WIDTH-1:0] sample, sample_nxt;
  logic [DATA_WIDTH-1:0] result, result_nxt;
  logic [WCW-1:0]        wait_cnt, wait_cnt_nxt;
  logic                  err_timeout, err_timeout_nxt;
  logic                  err_spurious, err_spurious_nxt;
  logic [CNT_WIDTH-1:0]  i_cnt, i_cnt_nxt;
  logic [CNT_WIDTH-1:0]  q_cnt, q_cnt_nxt;

  logic i_elig, q_elig, pick_q;

  // A channel can only be started if its result will have somewhere to go.
  assign i_elig = !bus.i_empty && !bus.i_out_full;
  assign q_elig = !bus.q_empty && !bus.q_out_full;
  // Ties go to the channel that was not served last; last_ch resets to Q so I wins first.
  assign pick_q = q_elig && (!i_elig || !last_ch);

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_ch      <= 1'b1;
      tag          <= 1'b0;
      sample       <= '0;
      result       <= '0;
      wait_cnt     <= '0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      i_cnt        <= '0;
      q_cnt        <= '0;
    end else begin
      state        <= state_nxt;
      last_ch      <= last_ch_nxt;
      tag          <= tag_nxt;
      sample       <= sample_nxt;
      result       <= result_nxt;
      wait_cnt     <= wait_cnt_nxt;
      err_timeout  <= err_timeout_nxt;
      err_spurious <= err_spurious_nxt;
      i_cnt        <= i_cnt_nxt;
      q_cnt        <= q_cnt_nxt;
    end
  end

  // Next-state logic and handshake strobes for the arbitration FSM.
  always_comb begin
    state_nxt        = state;
    last_ch_nxt      = last_ch;
    tag_nxt          = tag;
    sample_nxt       = sample;
    result_nxt       = result;
    wait_cnt_nxt     = wait_cnt;
    err_timeout_nxt  = err_timeout;
    err_spurious_nxt = err_spurious;
    i_cnt_nxt        = i_cnt;
    q_cnt_nxt        = q_cnt;
    bus.i_rd_en      = 1'b0;
    bus.q_rd_en      = 1'b0;
    bus.pu_valid     = 1'b0;
    bus.pu_din       = '0;
    bus.i_out_wr_en  = 1'b0;
    bus.i_out_din    = '0;
    bus.q_out_wr_en  = 1'b0;
    bus.q_out_din    = '0;

    case (state)
      IDLE: begin
        // rd_en is combinational from the FIFO flags, so it must be gated while reset is held.
        if (!reset && (i_elig || q_elig)) begin
          tag_nxt   = pick_q;
          state_nxt = ISSUE;
          if (pick_q) begin
            bus.q_rd_en = 1'b1;
            sample_nxt  = bus.q_dout;
          end else begin
            bus.i_rd_en = 1'b1;
            sample_nxt  = bus.i_dout;
          end
        end
      end
      ISSUE: begin
        bus.pu_valid = 1'b1;
        bus.pu_din   = sample;
        if (bus.pu_ready) begin
          wait_cnt_nxt = '0;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt + WCW'(1);
        // A result in the last allowed cycle still wins over the timeout.
        if (bus.pu_out_valid) begin
          result_nxt = bus.pu_out;
          state_nxt  = WRITE;
        end else if (wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_nxt = 1'b1;
          last_ch_nxt     = tag;
          state_nxt       = IDLE;
        end
      end
      WRITE: begin
        // Hold the result here until the tagged output has room; it is never dropped.
        if (!tag && !bus.i_out_full) begin
          bus.i_out_wr_en = 1'b1;
          bus.i_out_din   = result;
          i_cnt_nxt       = i_cnt + CNT_WIDTH'(1);
          last_ch_nxt     = tag;
          state_nxt       = IDLE;
        end else if (tag && !bus.q_out_full) begin
          bus.q_out_wr_en = 1'b1;
          bus.q_out_din   = result;
          q_cnt_nxt       = q_cnt + CNT_WIDTH'(1);
          last_ch_nxt     = tag;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A PU result with no transaction waiting for it is discarded and flagged.
    if (bus.pu_out_valid && state != WAIT)
      err_spurious_nxt = 1'b1;
  end

  assign bus.active_ch    = tag;
  assign bus.err_timeout  = err_timeout;
  assign bus.err_spurious = err_spurious;
  assign bus.i_count      = i_cnt;
  assign bus.q_count      = q_cnt;

endmodule
